divider_arbiter: RTL and testbench
==================================

# divider_arbiter

Shares one 8-bit non-restoring divider among `N_REQ` requesters, sequencing it job by job. It round-robin grants one requester and latches that requester's operands. It short-circuits divide-by-zero, drives the divider's req/ack handshake and guards against a hung divider with a timeout. After every job it pulses a clear so the divider returns to idle. It sits between client blocks and the divider datapath.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 64: maximum cycles spent waiting for `div_ack`.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `rq_req` in `N_REQ`: per-requester request level. Held high, with operands stable, until that requester's `rq_ack`.
- `rq_values` in `16*N_REQ`: requester i at `[16i+15:16i]`, laid out as {dividend[15:8], divisor[7:0]}.
- `rq_ack` out `N_REQ`: one-cycle completion pulse, one-hot to the granted requester.
- `rq_result` out 16: {remainder[15:8], quotient[7:0]}. Valid while `rq_ack` is high.
- `rq_err` out 1: valid with `rq_ack`. 1 = divide-by-zero or timeout.
- `grant_id` out `$clog2(N_REQ)`: index of the requester being served.
- `busy` out 1: high in every state except IDLE.
- `div_req` out 1: request to the divider.
- `div_values` out 16: operands to the divider, held stable for the whole job.
- `div_ack` in 1: divider completion pulse.
- `div_result` in 16: divider result, sampled on `div_ack`.
- `div_clr_n` out 1: registered active-low clear to the divider. Low for exactly one cycle per job.

## Operation
- States: IDLE, BUSY, DONE, CLEAR.
- **IDLE**
  - If any `rq_req` bit is high, the round-robin picker selects a winner. The search starts at pointer `ptr`; reset value of `ptr` is 0.
  - Register `grant_id`, latch the winner's operands into `div_values`, and set `ptr <= winner+1` (mod `N_REQ`).
  - If the latched divisor is nonzero: go to BUSY. `div_req` is 1 from BUSY entry.
  - If the divisor is 0: go to DONE with result `16'hFFFF`, err=1. The divider is not requested.
- **BUSY**
  - `div_req` = 1. A timeout counter starts at 0 on entry and increments each cycle.
  - On `div_ack`: capture `div_result`, err=0, `div_req` <= 0, go to DONE.
  - Counter at `TIMEOUT-1` with no `div_ack`: result `16'h0000`, err=1, `div_req` <= 0, go to DONE.
  - `div_ack` and timeout in the same cycle: `div_ack` wins.
- **DONE**
  - `rq_ack[grant_id]` = 1 for this single cycle.
  - `rq_result` and `rq_err` are driven from registers.
  - Go to CLEAR.
- **CLEAR**
  - `div_clr_n` = 0 for this single cycle; go to IDLE. CLEAR is entered on every path, including divide-by-zero.
- `div_ack` outside BUSY is ignored.
- Requesters must drop `rq_req` by the cycle after their `rq_ack`. IDLE resamples 2 cycles after the `rq_ack` cycle, so there is no spurious re-grant.
- `rq_req` bits that change while the arbiter is not in IDLE have no effect until IDLE.

## Timing
- Reset values:
  - `div_req`=0, `div_values`=0, `div_clr_n`=1.
  - `rq_ack`=0, `rq_result`=0, `rq_err`=0.
  - `grant_id`=0, `busy`=0, `ptr`=0, state=IDLE.
- `rq_req` first seen high in IDLE at edge k:
  - BUSY and `div_req` are high from cycle k+1.
  - `div_ack` arrives in cycle j. `rq_ack` is then high in cycle j+1, and `div_clr_n` is low in cycle j+2.
  - IDLE is back in cycle j+3.
- Divide-by-zero: `rq_ack` is high at k+1 and CLEAR is at k+2.
- Timeout: the job is abandoned after exactly `TIMEOUT` BUSY cycles.
- Reset mid-job: all state and outputs return to their reset values asynchronously, and no `rq_ack` is issued for the aborted job.
- Back-to-back throughput: one job per (divider latency + 3) cycles.

## Structure
- Package `div_arb_pkg` holds:
  - the state enum;
  - `DIV_ZERO_RESULT` = `16'hFFFF` and `TIMEOUT_RESULT` = `16'h0000`;
  - operand and result field widths.
- Sub-module `rr_picker`: combinational round-robin selection from `rq_req` and `ptr`. Outputs are the winner index and an any-request flag.

## Test plan
- **Single divide:** requester 1 sends dividend 200, divisor 7 → `div_values`=`16'hC807`; `rq_ack[1]` pulses once with `rq_result`=`16'h041C` (r=4, q=28), `rq_err`=0; `div_clr_n` is low one cycle later.
- **Contention:** requesters 0 and 2 request continuously with 100/10 → grants alternate 0,2,0,2; each result is `16'h000A`; requesters 1 and 3 are never acked.
- **Divide-by-zero:** requester 3 sends 55/0 → `div_req` never rises; `rq_ack[3]` at k+1 with `16'hFFFF`, err=1; `div_clr_n` pulses at k+2.
- **Timeout:** divider model never acks → after 64 BUSY cycles `rq_ack` rises with `16'h0000`, err=1, followed by one `div_clr_n` pulse; the next job then completes normally.
- **Simultaneous:** `div_ack` lands on the final timeout cycle → the result is taken from `div_result` with err=0.
- **Reset mid-job:** `reset_n` pulsed low in BUSY → all outputs return to reset values at once and no `rq_ack` is issued; a pending requester is granted afresh, starting from `ptr`=0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_arb_pkg;

    localparam int OPERAND_W = 8;
    localparam int VALUES_W  = 2 * OPERAND_W;
    localparam int RESULT_W  = 16;

    localparam logic [RESULT_W-1:0] DIV_ZERO_RESULT = 16'hFFFF;
    localparam logic [RESULT_W-1:0] TIMEOUT_RESULT  = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [OPERAND_W-1:0] dividend;
        logic [OPERAND_W-1:0] divisor;
    } operands_t;

    typedef struct packed {
        logic [OPERAND_W-1:0] remainder;
        logic [OPERAND_W-1:0] quotient;
    } result_t;

endpackage

// File: rtl/divider_arbiter_if.sv
// Requester-side and divider-side signals of the divider arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold rq_req until rq_ack; divider completes via div_ack.
interface divider_arbiter_if #(
    parameter int N_REQ = 4
);
    import div_arb_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]          rq_req;
    logic [VALUES_W*N_REQ-1:0] rq_values;
    logic [N_REQ-1:0]          rq_ack;
    logic [RESULT_W-1:0]       rq_result;
    logic                      rq_err;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic                      div_req;
    logic [VALUES_W-1:0]       div_values;
    logic                      div_ack;
    logic [RESULT_W-1:0]       div_result;
    logic                      div_clr_n;

    // Arbiter view.
    modport slave (
        input  rq_req, rq_values, div_ack, div_result,
        output rq_ack, rq_result, rq_err, grant_id, busy,
               div_req, div_values, div_clr_n
    );

    // Client / divider view.
    modport master (
        output rq_req, rq_values, div_ack, div_result,
        input  rq_ack, rq_result, rq_err, grant_id, busy,
               div_req, div_values, div_clr_n
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin winner selection: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; any_req flags whether winner is meaningful.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any_req
);

    // Scan from ptr upward, wrapping at N_REQ; the first hit wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one 8-bit divider among N_REQ requesters, one job at a time, round-robin.
// Latency: grant +1 cycle, rq_ack 1 cycle after div_ack, clear 1 cycle later (div latency + 3 per job).
// Backpressure: requests wait in IDLE until the previous job's clear cycle has passed.
module divider_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    divider_arbiter_if.slave bus
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ACK_ONE = N_REQ'(1);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [TCNT_W-1:0]   tcnt;
    logic [ID_W-1:0]     grant_id;
    logic                busy;
    logic                div_req;
    operands_t           div_values;
    logic                div_clr_n;
    logic [N_REQ-1:0]    rq_ack;
    logic [RESULT_W-1:0] rq_result;
    logic                rq_err;

    logic [ID_W-1:0]     winner;
    logic                any_req;
    operands_t           win_ops;
    logic [ID_W-1:0]     ptr_next;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req     (bus.rq_req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Operand mux for the current winner; pointer advances past it with wrap.
    always_comb begin
        win_ops = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_ops = bus.rq_values[VALUES_W*i +: VALUES_W];
            end
        end
        ptr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end

    // Job sequencer: grant, run divider (or short-circuit), report, clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            tcnt       <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            div_req    <= 1'b0;
            div_values <= '0;
            div_clr_n  <= 1'b1;
            rq_ack     <= '0;
            rq_result  <= '0;
            rq_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id   <= winner;
                        div_values <= win_ops;
                        ptr        <= ptr_next;
                        busy       <= 1'b1;
                        tcnt       <= '0;
                        if (win_ops.divisor != '0) begin
                            div_req <= 1'b1;
                            state   <= ST_BUSY;
                        end else begin
                            // Divide-by-zero never touches the divider.
                            rq_result <= DIV_ZERO_RESULT;
                            rq_err    <= 1'b1;
                            rq_ack    <= ACK_ONE << winner;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    // A completion on the last timeout cycle still counts as success.
                    if (bus.div_ack) begin
                        rq_result <= bus.div_result;
                        rq_err    <= 1'b0;
                        div_req   <= 1'b0;
                        rq_ack    <= ACK_ONE << grant_id;
                        state     <= ST_DONE;
                    end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        rq_result <= TIMEOUT_RESULT;
                        rq_err    <= 1'b1;
                        div_req   <= 1'b0;
                        rq_ack    <= ACK_ONE << grant_id;
                        state     <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    rq_ack    <= '0;
                    div_clr_n <= 1'b0;
                    state     <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    div_clr_n <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant_id   = grant_id;
    assign bus.busy       = busy;
    assign bus.div_req    = div_req;
    assign bus.div_values = div_values;
    assign bus.div_clr_n  = div_clr_n;
    assign bus.rq_ack     = rq_ack;
    assign bus.rq_result  = rq_result;
    assign bus.rq_err     = rq_err;

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter: vector table, contention and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_divider_arbiter;
    import div_arb_pkg::*;

    localparam int N_REQ = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    divider_arbiter_if #(.N_REQ(N_REQ)) bus ();

    divider_arbiter #(.N_REQ(N_REQ), .TIMEOUT(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] res;
        logic        err;
        int          cyc;
    } vec_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   ack_cnt  = 0;
    int   dreq_cnt = 0;
    int   dm_lat   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Divider model: acks dm_lat cycles into a request (0 = never acks).
    initial begin
        int        dcnt;
        operands_t o;
        dcnt           = 0;
        bus.div_ack    = 1'b0;
        bus.div_result = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            if (bus.div_req) dcnt++;
            else dcnt = 0;
            if (dm_lat != 0 && bus.div_req && dcnt == dm_lat) begin
                o              = bus.div_values;
                bus.div_ack    = 1'b1;
                bus.div_result = {o.dividend % o.divisor, o.dividend / o.divisor};
            end else begin
                bus.div_ack    = 1'b0;
                bus.div_result = 16'hDEAD;
            end
        end
    end

    // Scoreboard monitor: every rq_ack cycle pops one expected completion.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.div_req) dreq_cnt++;
            if (reset_n && bus.rq_ack != '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: rq_ack=%b with no job outstanding", bus.rq_ack);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_onehot", 32'(bus.rq_ack), 32'(1 << e.id));
                    chk("rq_result", 32'(bus.rq_result), 32'(e.res));
                    chk("rq_err", 32'(bus.rq_err), 32'(e.err));
                end
                ack_cnt++;
            end
        end
    end

    task automatic wait_ack(input int lim, output int n);
        n = 0;
        for (int i = 1; i <= lim; i++) begin
            @(posedge clk);
            #1;
            if (bus.rq_ack != '0) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_wait: no rq_ack within %0d cycles", lim);
        end
    endtask

    task automatic run_job(input vec_t v);
        int n;
        int d0;
        dm_lat = v.lat;
        bus.rq_values[16*v.id +: 16] = {v.a, v.b};
        sb.push_back('{v.id, v.res, v.err});
        d0 = dreq_cnt;
        bus.rq_req[v.id] = 1'b1;
        wait_ack(200, n);
        chk("ack_latency", n, v.cyc);
        chk("grant_id", 32'(bus.grant_id), v.id);
        chk("div_values", 32'(bus.div_values), 32'({v.a, v.b}));
        chk("div_req_done", 32'(bus.div_req), 0);
        chk("busy_done", 32'(bus.busy), 1);
        bus.rq_req[v.id] = 1'b0;
        if (v.b == 8'd0) chk("divzero_no_div_req", dreq_cnt - d0, 0);
        @(posedge clk);
        #1;
        chk("clr_low", 32'(bus.div_clr_n), 0);
        chk("rq_ack_single", 32'(bus.rq_ack), 0);
        @(posedge clk);
        #1;
        chk("clr_high", 32'(bus.div_clr_n), 1);
        chk("busy_idle", 32'(bus.busy), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_div_req"},    32'(bus.div_req), 0);
        chk({tag, "_div_values"}, 32'(bus.div_values), 0);
        chk({tag, "_div_clr_n"},  32'(bus.div_clr_n), 1);
        chk({tag, "_rq_ack"},     32'(bus.rq_ack), 0);
        chk({tag, "_rq_result"},  32'(bus.rq_result), 0);
        chk({tag, "_rq_err"},     32'(bus.rq_err), 0);
        chk({tag, "_grant_id"},   32'(bus.grant_id), 0);
        chk({tag, "_busy"},       32'(bus.busy), 0);
    endtask

    initial begin
        vec_t tbl[11];
        int   a0;
        // id, dividend, divisor, divider latency, result, err, cycles to rq_ack
        tbl[0]  = '{1, 8'd200, 8'd7,   3,  16'h041C, 1'b0, 4};
        tbl[1]  = '{3, 8'd55,  8'd0,   3,  16'hFFFF, 1'b1, 1};
        tbl[2]  = '{0, 8'd255, 8'd16,  1,  16'h0F0F, 1'b0, 2};
        tbl[3]  = '{2, 8'd7,   8'd9,   5,  16'h0700, 1'b0, 6};
        tbl[4]  = '{3, 8'd0,   8'd5,   2,  16'h0000, 1'b0, 3};
        tbl[5]  = '{1, 8'd255, 8'd1,   4,  16'h00FF, 1'b0, 5};
        tbl[6]  = '{2, 8'd128, 8'd3,   2,  16'h022A, 1'b0, 3};
        tbl[7]  = '{0, 8'd100, 8'd10,  0,  16'h0000, 1'b1, 65};
        tbl[8]  = '{1, 8'd9,   8'd2,   2,  16'h0104, 1'b0, 3};
        tbl[9]  = '{2, 8'd100, 8'd10,  64, 16'h000A, 1'b0, 65};
        tbl[10] = '{3, 8'd250, 8'd250, 63, 16'h0001, 1'b0, 64};

        reset_n       = 1'b0;
        bus.rq_req    = '0;
        bus.rq_values = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention from ptr=0: requesters 0 and 2 alternate.
        dm_lat = 2;
        bus.rq_values[16*0 +: 16] = {8'd100, 8'd10};
        bus.rq_values[16*2 +: 16] = {8'd100, 8'd10};
        for (int k = 0; k < 4; k++) sb.push_back('{(k % 2) * 2, 16'h000A, 1'b0});
        a0 = ack_cnt;
        bus.rq_req[0] = 1'b1;
        bus.rq_req[2] = 1'b1;
        for (int i = 0; i < 400 && ack_cnt < a0 + 4; i++) begin
            @(posedge clk);
            #1;
        end
        bus.rq_req = '0;
        chk("contention_acks", ack_cnt - a0, 4);
        repeat (4) @(posedge clk);
        #1;
        chk("contention_quiet", 32'(bus.busy), 0);

        for (int i = 0; i < 11; i++) run_job(tbl[i]);

        // Reset mid-job: requester 1 in BUSY leaves ptr at 2; after reset ptr=0 picks 1 over 3.
        dm_lat = 0;
        bus.rq_values[16*1 +: 16] = {8'd200, 8'd7};
        bus.rq_values[16*3 +: 16] = {8'd9, 8'd2};
        bus.rq_req[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.busy), 1);
        chk("mid_grant", 32'(bus.grant_id), 1);
        chk("mid_div_req", 32'(bus.div_req), 1);
        bus.rq_req[3] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{1, 16'h041C, 1'b0});
        sb.push_back('{3, 16'h0104, 1'b0});
        dm_lat  = 2;
        a0      = ack_cnt;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("regrant_ptr0", 32'(bus.grant_id), 1);
        chk("regrant_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 100 && bus.rq_req != '0; i++) begin
            @(posedge clk);
            #1;
            if (bus.rq_ack[1]) bus.rq_req[1] = 1'b0;
            if (bus.rq_ack[3]) bus.rq_req[3] = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_acks", ack_cnt - a0, 2);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
